// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write signals of the program loader.
// The loader takes the slave view; the stream source / memory side takes the master view.
interface imem_loader_if #(
    parameter int ADDR_W = 5
);
    logic              start;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_last;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [ADDR_W:0]   word_count;
    logic              busy;
    logic              done;
    logic              overflow;

    modport slave (
        input  start, byte_in, byte_valid, byte_last,
        output byte_ready, wr_en, wr_addr, wr_data, word_count, busy, done, overflow
    );

    modport master (
        output start, byte_in, byte_valid, byte_last,
        input  byte_ready, wr_en, wr_addr, wr_data, word_count, busy, done, overflow
    );
endinterface

// File: rtl/imem_loader.sv
// Assembles a little-endian byte stream into 32-bit instruction words and
// writes them to instruction memory from word address 0 upward.
module imem_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_loader_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       asm_q, asm_d;
    logic              last_seen_q, last_seen_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic              byte_ready_q, byte_ready_d;
    logic              wr_en_q, wr_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              overflow_q, overflow_d;
    logic              accept;

    assign accept = bus.byte_valid & byte_ready_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        idx_d        = idx_q;
        asm_d        = asm_q;
        last_seen_d  = last_seen_q;
        word_count_d = word_count_q;
        done_d       = done_q;
        overflow_d   = overflow_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d      = LOAD;
                    addr_d       = '0;
                    idx_d        = '0;
                    asm_d        = '0;
                    last_seen_d  = 1'b0;
                    word_count_d = '0;
                    done_d       = 1'b0;
                    overflow_d   = 1'b0;
                end
            end
            LOAD: begin
                if (accept) begin
                    // Upper lanes were cleared at the previous write, so a
                    // short final word is zero-padded for free.
                    asm_d[{idx_q, 3'b000} +: 8] = bus.byte_in;
                    idx_d       = idx_q + 2'd1;
                    last_seen_d = bus.byte_last;
                    if (idx_q == 2'd3 || bus.byte_last) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                word_count_d = word_count_q + (ADDR_W+1)'(1);
                idx_d        = '0;
                asm_d        = '0;
                if (last_seen_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (addr_q == LAST_ADDR) begin
                    state_d    = DONE;
                    done_d     = 1'b1;
                    overflow_d = 1'b1;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake and strobe outputs follow the next state so they are
        // valid as flops in the cycle the state takes effect.
        byte_ready_d = (state_d == LOAD);
        wr_en_d      = (state_d == WRITE);
        busy_d       = (state_d == LOAD) || (state_d == WRITE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            idx_q        <= '0;
            asm_q        <= '0;
            last_seen_q  <= 1'b0;
            word_count_q <= '0;
            byte_ready_q <= 1'b0;
            wr_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            idx_q        <= idx_d;
            asm_q        <= asm_d;
            last_seen_q  <= last_seen_d;
            word_count_q <= word_count_d;
            byte_ready_q <= byte_ready_d;
            wr_en_q      <= wr_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = addr_q;
    assign bus.wr_data    = asm_q;
    assign bus.word_count = word_count_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.overflow   = overflow_q;
endmodule
